// File: rtl/rv_go_pkg.sv
// Shared encodings for the rv_go memory arbiter: load/store op codes, access sizes
// and arbiter FSM states.
package rv_go_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_IF = 2'd1,
    ST_WAIT_D  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  // Unsupported op codes fall back to word accesses
  function automatic mem_size_e op_size(input logic [2:0] op);
    case (op)
      MEM_B, MEM_BU: op_size = SZ_B;
      MEM_H, MEM_HU: op_size = SZ_H;
      MEM_W:         op_size = SZ_W;
      default:       op_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/rv_go_lsu_align.sv
// Combinational load/store lane handling: store strobes and lane replication,
// misalignment detection, and load byte/half extraction with sign/zero extension.
module rv_go_lsu_align
  import rv_go_pkg::*;
(
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_lo,
  input  logic [31:0] req_wdata,
  output logic        misaligned,
  output logic [3:0]  st_strb,
  output logic [31:0] st_lane,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;
  logic        ld_sext;

  // Request side: strobes, replicated write lanes and alignment check
  always_comb begin
    misaligned = 1'b0;
    st_strb    = 4'b1111;
    st_lane    = req_wdata;
    case (op_size(req_op))
      SZ_B: begin
        st_strb = 4'b0001 << req_lo;
        st_lane = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        st_strb    = 4'b0011 << req_lo;
        st_lane    = {2{req_wdata[15:0]}};
        misaligned = req_lo[0];
      end
      default: begin
        misaligned = |req_lo;
      end
    endcase
  end

  // Response side: bring the addressed lane down to bit 0, then extend
  always_comb begin
    ld_shift = ld_raw >> {ld_lo, 3'b000};
    ld_sext  = ~ld_op[2];
    case (op_size(ld_op))
      SZ_B:    ld_data = {{24{ld_sext & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = {{16{ld_sext & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/rv_go_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store with a
// D-over-IF priority, IF starvation guard and one outstanding transaction.
module rv_go_mem_arbiter
  import rv_go_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  arb_state_e          state, state_nxt;
  logic                err_pend, err_pend_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                d_we_q;
  logic [2:0]          d_op_q;
  logic [1:0]          d_lo_q;
  logic                d_ok, d_grant, if_grant, misaligned;
  logic [3:0]          st_strb;
  logic [31:0]         st_lane, ld_data;

  rv_go_lsu_align u_align (
    .req_op     (d_op),
    .req_lo     (d_addr[1:0]),
    .req_wdata  (d_wdata),
    .misaligned (misaligned),
    .st_strb    (st_strb),
    .st_lane    (st_lane),
    .ld_op      (d_op_q),
    .ld_lo      (d_lo_q),
    .ld_raw     (mem_rdata),
    .ld_data    (ld_data)
  );

  // State, streak, pending error and the captured D request attributes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      err_pend <= 1'b0;
      streak   <= '0;
      d_we_q   <= 1'b0;
      d_op_q   <= 3'b000;
      d_lo_q   <= 2'b00;
    end else begin
      state    <= state_nxt;
      err_pend <= err_pend_nxt;
      streak   <= streak_nxt;
      if (d_grant) begin
        d_we_q <= d_we;
        d_op_q <= d_op;
        d_lo_q <= d_addr[1:0];
      end
    end
  end

  // Arbitration, memory request drive and response routing
  always_comb begin
    state_nxt    = state;
    err_pend_nxt = 1'b0;
    d_grant      = 1'b0;
    if_grant     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wstrb    = 4'b0000;
    mem_wdata    = 32'h0;
    if_rvalid    = 1'b0;
    if_rdata     = 32'h0;
    d_rvalid     = 1'b0;
    d_rdata      = 32'h0;
    d_err        = 1'b0;
    d_ok         = d_req && !err_pend && (!if_req || (streak < STREAK_W'(MAX_D_STREAK)));

    if (!rst) begin
      if (err_pend) begin
        d_rvalid = 1'b1;
        d_err    = 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (d_ok && !misaligned) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr & ~32'h3;
            mem_wstrb = d_we ? st_strb : 4'b0000;
            mem_wdata = d_we ? st_lane : 32'h0;
            if (mem_gnt) begin
              d_grant   = 1'b1;
              state_nxt = ST_WAIT_D;
            end
          end else begin
            // A rejected D access still lets a waiting fetch go out this cycle
            err_pend_nxt = d_ok;
            if (if_req) begin
              mem_req  = 1'b1;
              mem_addr = if_addr & ~32'h3;
              if (mem_gnt) begin
                if_grant  = 1'b1;
                state_nxt = ST_WAIT_IF;
              end
            end
          end
        end
        ST_WAIT_IF: begin
          if (mem_rvalid) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
            state_nxt = ST_IDLE;
          end
        end
        ST_WAIT_D: begin
          if (mem_rvalid) begin
            d_rvalid  = 1'b1;
            d_rdata   = d_we_q ? 32'h0 : ld_data;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    if (!if_req || if_grant)
      streak_nxt = '0;
    else if (d_grant && (streak < STREAK_W'(MAX_D_STREAK)))
      streak_nxt = streak + STREAK_W'(1);
    else
      streak_nxt = streak;
  end

endmodule

// File: tb/tb_rv_go_mem_arbiter.sv
// Directed bench for rv_go_mem_arbiter: a table of single D accesses plus
// hand-written sequences for stalls, priority, rejected accesses and reset.
module tb_rv_go_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_op;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_go_mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_op       (d_op),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] raw;
    logic        e_req;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " mem_req"},   32'(mem_req),   32'h0);
    check({tag, " d_rvalid"},  32'(d_rvalid),  32'h0);
    check({tag, " if_rvalid"}, 32'(if_rvalid), 32'h0);
    check({tag, " d_err"},     32'(d_err),     32'h0);
    check({tag, " d_rdata"},   d_rdata,        32'h0);
    check({tag, " mem_addr"},  mem_addr,       32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int     grants;
    logic   got_d [10];

    //          we op      addr        wdata         raw           req addr       strb     wdata         rdata         err
    vecs[0]  = '{0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80, 0};
    vecs[1]  = '{1, 3'b001, 32'h102, 32'h1234ABCD, 32'hDEADBEEF, 1, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0,        0};
    vecs[2]  = '{0, 3'b010, 32'h201, 32'h0,        32'hFFFFFFFF, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1};
    vecs[3]  = '{0, 3'b100, 32'h101, 32'h0,        32'h12345678, 1, 32'h100, 4'b0000, 32'h0,        32'h00000056, 0};
    vecs[4]  = '{0, 3'b001, 32'h002, 32'h0,        32'h80017FFF, 1, 32'h000, 4'b0000, 32'h0,        32'hFFFF8001, 0};
    vecs[5]  = '{0, 3'b101, 32'h002, 32'h0,        32'h80017FFF, 1, 32'h000, 4'b0000, 32'h0,        32'h00008001, 0};
    vecs[6]  = '{0, 3'b001, 32'h000, 32'h0,        32'h12347FFF, 1, 32'h000, 4'b0000, 32'h0,        32'h00007FFF, 0};
    vecs[7]  = '{1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        1, 32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0,        0};
    vecs[8]  = '{1, 3'b010, 32'h404, 32'hCAFEF00D, 32'h0,        1, 32'h404, 4'b1111, 32'hCAFEF00D, 32'h0,        0};
    vecs[9]  = '{0, 3'b010, 32'h404, 32'h0,        32'h11223344, 1, 32'h404, 4'b0000, 32'h0,        32'h11223344, 0};
    vecs[10] = '{1, 3'b001, 32'h103, 32'h5555AAAA, 32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        1};
    vecs[11] = '{0, 3'b101, 32'h001, 32'h0,        32'hFFFFFFFF, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1};
    vecs[12] = '{0, 3'b011, 32'h010, 32'h0,        32'hA5A50F0F, 1, 32'h010, 4'b0000, 32'h0,        32'hA5A50F0F, 0};
    vecs[13] = '{0, 3'b111, 32'h012, 32'h0,        32'hFFFFFFFF, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1};
    vecs[14] = '{1, 3'b000, 32'h000, 32'hFFFFFF7E, 32'h0,        1, 32'h000, 4'b0001, 32'h7E7E7E7E, 32'h0,        0};
    vecs[15] = '{0, 3'b000, 32'h000, 32'h0,        32'h0000007F, 1, 32'h000, 4'b0000, 32'h0,        32'h0000007F, 0};
    vecs[16] = '{0, 3'b000, 32'h002, 32'h0,        32'h00800000, 1, 32'h000, 4'b0000, 32'h0,        32'hFFFFFF80, 0};
    vecs[17] = '{1, 3'b110, 32'h020, 32'h01020304, 32'h0,        1, 32'h020, 4'b1111, 32'h01020304, 32'h0,        0};

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_op = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // Reset state
    @(negedge clk);
    check_idle_outputs("reset");
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Table of single D accesses, immediate grant, response one cycle later
    for (int i = 0; i < NV; i++) begin
      d_req = 1'b1; d_we = vecs[i].we; d_op = vecs[i].op;
      d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      mem_gnt = 1'b1; mem_rvalid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) begin
        check($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vecs[i].we));
        check($sformatf("v%0d mem_addr", i),  mem_addr,       vecs[i].e_addr);
        check($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_strb));
        check($sformatf("v%0d mem_wdata", i), mem_wdata,      vecs[i].e_wdata);
      end
      next_cycle();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = vecs[i].raw;
      @(negedge clk);
      check($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'h1);
      check($sformatf("v%0d d_err", i),    32'(d_err),    32'(vecs[i].e_err));
      check($sformatf("v%0d d_rdata", i),  d_rdata,       vecs[i].e_rdata);
      check($sformatf("v%0d mem_req2", i), 32'(mem_req),  32'h0);
      next_cycle();
      d_req = 1'b0; mem_rvalid = 1'b0;
    end

    // Grant withheld for 5 cycles, then a response 3 cycles late
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h500; mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d mem_req", i), 32'(mem_req), 32'h1);
      check($sformatf("stall%0d mem_addr", i), mem_addr, 32'h500);
      next_cycle();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    check("stall gnt mem_req", 32'(mem_req), 32'h1);
    next_cycle();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("late%0d d_rvalid", i), 32'(d_rvalid), 32'h0);
      check($sformatf("late%0d mem_req", i), 32'(mem_req), 32'h0);
      next_cycle();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("late d_rvalid", 32'(d_rvalid), 32'h1);
    check("late d_rdata", d_rdata, 32'h55AA55AA);
    next_cycle();
    d_req = 1'b0; mem_rvalid = 1'b0;

    // Misaligned D while IF pending: IF goes out, error reported next cycle
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h201;
    if_req = 1'b1; if_addr = 32'h80; mem_gnt = 1'b1;
    @(negedge clk);
    check("mis+if mem_req", 32'(mem_req), 32'h1);
    check("mis+if mem_addr", mem_addr, 32'h80);
    check("mis+if d_rvalid0", 32'(d_rvalid), 32'h0);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
    @(negedge clk);
    check("mis+if d_rvalid", 32'(d_rvalid), 32'h1);
    check("mis+if d_err", 32'(d_err), 32'h1);
    check("mis+if d_rdata", d_rdata, 32'h0);
    check("mis+if if_rvalid", 32'(if_rvalid), 32'h1);
    check("mis+if if_rdata", if_rdata, 32'h00000013);
    next_cycle();
    d_req = 1'b0; if_req = 1'b0; mem_rvalid = 1'b0;
    next_cycle();

    // Both requesters held, memory always ready: D,D,D,D,IF repeating
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h80;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    grants = 0;
    for (int c = 0; c < 40 && grants < 10; c++) begin
      @(negedge clk);
      if (mem_req) begin
        got_d[grants] = (mem_addr == 32'h40);
        grants++;
      end
      if (grants < 10) next_cycle();
    end
    check("prio grant count", 32'(grants), 32'd10);
    for (int g = 0; g < grants; g++)
      check($sformatf("prio grant%0d is_d", g), 32'(got_d[g]), (g % 5 == 4) ? 32'h0 : 32'h1);
    next_cycle();
    d_req = 1'b0; if_req = 1'b0;
    next_cycle();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    next_cycle();

    // Reset during WAIT_D, then a stale response
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h600; mem_gnt = 1'b1;
    next_cycle();
    rst = 1'b1; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check_idle_outputs("rst mid");
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("stale d_rvalid", 32'(d_rvalid), 32'h0);
    check("stale d_rdata", d_rdata, 32'h0);
    check("stale mem_req", 32'(mem_req), 32'h0);
    next_cycle();
    mem_rvalid = 1'b0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
